uart_frame_rx: RTL and testbench

Serial receive path of the badge UART. Samples an 8N1 asynchronous line and assembles FRAME_SIZE consecutive bytes into one parallel frame. It presents the frame on a valid/ready handshake, so the fabric can consume multi-byte commands from the host. It is the receive-side counterpart of the frame transmitter that drives fixed multi-byte words out on a button trigger, and it uses the same frame width and byte order.

---
 rtl/uart_frame_rx.sv | 193 +++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that assembles FRAME_SIZE bytes into one frame, with the first byte in the MS byte.
// The frame is offered on a valid/ready handshake; framing, gap and overrun errors are one-cycle pulses.
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rxs
// START     | half-bit wait, then confirm the start bit
// DATA      | sampling DBITS data bits, LSB first
// STOP      | one bit-time wait, then check the stop bit
// WAIT_IDLE | framing error seen, wait for the line to go high
module uart_frame_rx #(
   parameter int CLKS_PER_BIT = 278,
   parameter int DBITS        = 8,
   parameter int FRAME_SIZE   = 4,
   parameter int GAP_BITS     = 20
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        rx,
   output logic [FRAME_SIZE*DBITS-1:0] frame_data,
   output logic                        frame_valid,
   input  logic                        frame_ready,
   output logic                        ferr,
   output logic                        gap_err,
   output logic                        overrun
);

   localparam int FW        = FRAME_SIZE * DBITS;
   localparam int TW        = $clog2(CLKS_PER_BIT);
   localparam int IW        = $clog2(FRAME_SIZE + 1);
   localparam int BW        = (DBITS > 1) ? $clog2(DBITS) : 1;
   localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
   localparam int GW        = $clog2(GAP_LIMIT + 1);

   // The timer counts down to zero inclusive, so loads are one less than the wanted interval.
   localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t            state, state_nxt;
   logic              rx_meta, rxs;
   logic [TW-1:0]     timer;
   logic [TW-1:0]     timer_val;
   logic              timer_ld;
   logic [BW-1:0]     bit_cnt;
   logic [DBITS-1:0]  shreg;
   logic [FW-1:0]     stage;
   logic [FW-1:0]     stage_nxt;
   logic [IW-1:0]     byte_idx;
   logic [GW-1:0]     gap_cnt;
   logic              start_det, sample_bit, byte_done, frame_err;
   logic              gap_run, gap_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      timer_ld   = 1'b0;
      timer_val  = FULL_LOAD;
      start_det  = 1'b0;
      sample_bit = 1'b0;
      byte_done  = 1'b0;
      frame_err  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rxs) begin
               state_nxt = S_START;
               timer_ld  = 1'b1;
               timer_val = HALF_LOAD;
               start_det = 1'b1;
            end
         end
         S_START: begin
            if (timer == '0) begin
               if (rxs) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_DATA;
                  timer_ld  = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (timer == '0) begin
               sample_bit = 1'b1;
               timer_ld   = 1'b1;
               if (bit_cnt == BW'(DBITS - 1)) state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (timer == '0) begin
               if (rxs) begin
                  byte_done = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  frame_err = 1'b1;
                  state_nxt = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (rxs) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer   <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         if (timer_ld)           timer <= timer_val;
         else if (timer != '0)   timer <= timer - TW'(1);
         if (start_det)          bit_cnt <= '0;
         else if (sample_bit)    bit_cnt <= bit_cnt + BW'(1);
         if (sample_bit)         shreg <= {rxs, shreg[DBITS-1:1]};
      end
   end

   // A low rxs in IDLE is a start detection, which also clears the gap timer.
   assign gap_run   = (state == S_IDLE) && (byte_idx != '0) && rxs;
   assign gap_hit   = gap_run && (gap_cnt == GW'(GAP_LIMIT - 1));
   assign stage_nxt = {stage[FW-DBITS-1:0], shreg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt <= '0;
      end else if (!gap_run || gap_hit) begin
         gap_cnt <= '0;
      end else begin
         gap_cnt <= gap_cnt + GW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage       <= '0;
         byte_idx    <= '0;
         frame_data  <= '0;
         frame_valid <= 1'b0;
         ferr        <= 1'b0;
         gap_err     <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         ferr    <= frame_err;
         gap_err <= gap_hit;
         overrun <= 1'b0;
         if (frame_valid && frame_ready) frame_valid <= 1'b0;
         if (frame_err || gap_hit) begin
            stage    <= '0;
            byte_idx <= '0;
         end else if (byte_done) begin
            if (byte_idx == IW'(FRAME_SIZE - 1)) begin
               stage    <= '0;
               byte_idx <= '0;
               // A frame being consumed on this same edge frees the output register.
               if (!frame_valid || frame_ready) begin
                  frame_data  <= stage_nxt;
                  frame_valid <= 1'b1;
               end else begin
                  overrun <= 1'b1;
               end
            end else begin
               stage    <= stage_nxt;
               byte_idx <= byte_idx + IW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: frames are queued as expected when sent, and a monitor
// compares each frame as it is consumed on the valid/ready handshake.
module tb_uart_frame_rx;

   localparam int CPB = 8;

   logic        clk;
   logic        rst_n;
   logic        rx;
   logic [31:0] frame_data;
   logic        frame_valid;
   logic        frame_ready;
   logic        ferr;
   logic        gap_err;
   logic        overrun;

   int n_checks  = 0;
   int n_fail    = 0;
   int ferr_seen = 0;
   int gap_seen  = 0;
   int ovr_seen  = 0;
   logic [31:0] exp_q[$];

   uart_frame_rx #(
      .CLKS_PER_BIT(CPB),
      .DBITS       (8),
      .FRAME_SIZE  (4),
      .GAP_BITS    (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .frame_data (frame_data),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .ferr       (ferr),
      .gap_err    (gap_err),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; the monitor samples 2 ns later.
   always begin
      @(negedge clk);
      #2;
      if (rst_n) begin
         if (ferr)    ferr_seen++;
         if (gap_err) gap_seen++;
         if (overrun) ovr_seen++;
         if (frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_frame: got %h, expected no frame", frame_data);
            end else begin
               check("frame", frame_data, exp_q.pop_front());
            end
         end
      end
   end

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send_frame(input logic [31:0] f);
      for (int i = 3; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
   endtask

   task automatic wait_drain(input string name);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < 300) begin
         @(negedge clk);
         i++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_valid(input string name);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         #2;
         got = frame_valid;
      end
      check(name, {31'd0, got}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n       = 1'b0;
      rx          = 1'b1;
      frame_ready = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check("reset_frame_data", frame_data, 32'h0);
      check("reset_valid", {31'd0, frame_valid}, 32'd0);
      check("reset_pulses", {29'd0, ferr, gap_err, overrun}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(10);

      // Four identical bytes, consumer always ready
      exp_q.push_back(32'h41414141);
      send_frame(32'h41414141);
      wait_drain("drain_41");
      idle(10);
      check("no_ferr_t1", 32'(ferr_seen), 32'd0);
      check("no_gap_t1", 32'(gap_seen), 32'd0);
      check("no_ovr_t1", 32'(ovr_seen), 32'd0);

      // Held frame while consumer is stalled
      frame_ready = 1'b0;
      exp_q.push_back(32'hDEADBEEF);
      send_frame(32'hDEADBEEF);
      wait_valid("valid_deadbeef");
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #2;
         if (i % 10 == 0) begin
            check("hold_valid", {31'd0, frame_valid}, 32'd1);
            check("hold_data", frame_data, 32'hDEADBEEF);
         end
      end
      @(negedge clk);
      frame_ready = 1'b1;
      @(posedge clk);
      #1;
      check("valid_fall", {31'd0, frame_valid}, 32'd0);
      wait_drain("drain_deadbeef");
      idle(10);

      // Short low glitch must not start a byte
      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      idle(30);
      check("glitch_no_valid", {31'd0, frame_valid}, 32'd0);
      exp_q.push_back(32'h01020304);
      send_frame(32'h01020304);
      wait_drain("drain_01020304");
      idle(10);

      // Framing error on the second byte discards the partial frame
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b0);
      idle(20);
      check("ferr_count", 32'(ferr_seen), 32'd1);
      exp_q.push_back(32'h11223344);
      send_frame(32'h11223344);
      wait_drain("drain_11223344");
      idle(10);

      // Idle gap mid-frame
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      idle(40);
      check("gap_count", 32'(gap_seen), 32'd1);
      exp_q.push_back(32'hA0A1A2A3);
      send_frame(32'hA0A1A2A3);
      wait_drain("drain_a0a1a2a3");
      idle(10);

      // Second frame while the first is still held
      frame_ready = 1'b0;
      exp_q.push_back(32'h01020304);
      send_frame(32'h01020304);
      send_frame(32'h05060708);
      idle(10);
      check("ovr_count", 32'(ovr_seen), 32'd1);
      check("ovr_data", frame_data, 32'h01020304);
      check("ovr_valid", {31'd0, frame_valid}, 32'd1);

      // Reset in the middle of a byte
      @(negedge clk);
      rx = 1'b0;
      repeat (20) @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_frame_data", frame_data, 32'h0);
      check("rst_valid", {31'd0, frame_valid}, 32'd0);
      check("rst_pulses", {29'd0, ferr, gap_err, overrun}, 32'd0);
      exp_q.delete();
      rx = 1'b1;
      repeat (4) @(negedge clk);
      rst_n       = 1'b1;
      frame_ready = 1'b1;
      idle(10);
      exp_q.push_back(32'h5A3C96F0);
      send_frame(32'h5A3C96F0);
      wait_drain("drain_after_reset");
      idle(10);

      check("final_ferr", 32'(ferr_seen), 32'd1);
      check("final_gap", 32'(gap_seen), 32'd1);
      check("final_ovr", 32'(ovr_seen), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
